sram_fault_responder: RTL and testbench

Memory-side responder for the BIST port: a 256 x 10 single-port synchronous SRAM model that answers the BIST controller's chip-select / write-enable / address / data interface and returns registered read data. It carries two programmable bit-fault entries (stuck-at-0, stuck-at-1, rising-transition) so the BIST controller's error detection can be exercised. It also keeps saturating access counters for coverage. It sits between `sram_bist` and the bench, in place of the fault-free SRAM.

---
 rtl/sram_fault_responder_if.sv | 36 +++
 rtl/sram_fault_responder.sv | 169 ++++++++++++++++
 tb/tb_sram_fault_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_fault_responder_if.sv
// Access, fault-programming and counter signals between the BIST controller
// (master) and the faulty SRAM responder (slave).
interface sram_fault_responder_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) ();
  logic              i_csn;
  logic              i_wen;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic              i_flt_wr;
  logic              i_flt_idx;
  logic [ADDR_W-1:0] i_flt_addr;
  logic [3:0]        i_flt_bit;
  logic [1:0]        i_flt_type;
  logic              i_cnt_clr;
  logic [CNT_W-1:0]  o_wr_cnt;
  logic [CNT_W-1:0]  o_rd_cnt;

  modport slave (
    input  i_csn, i_wen, i_addr, i_wr_data,
    input  i_flt_wr, i_flt_idx, i_flt_addr, i_flt_bit, i_flt_type,
    input  i_cnt_clr,
    output o_rd_data, o_rd_valid, o_wr_cnt, o_rd_cnt
  );

  modport master (
    output i_csn, i_wen, i_addr, i_wr_data,
    output i_flt_wr, i_flt_idx, i_flt_addr, i_flt_bit, i_flt_type,
    output i_cnt_clr,
    input  o_rd_data, o_rd_valid, o_wr_cnt, o_rd_cnt
  );
endinterface

// File: rtl/sram_fault_responder.sv
// Single-port synchronous SRAM model for BIST with two programmable single-bit
// fault entries (SA0 / SA1 / rising-transition) and saturating access counters.
module sram_fault_responder #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  sram_fault_responder_if.slave bus
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [1:0] FT_OFF = 2'b00;
  localparam logic [1:0] FT_SA0 = 2'b01;
  localparam logic [1:0] FT_SA1 = 2'b10;
  localparam logic [1:0] FT_TFU = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        bit_idx;
    logic [1:0]        ftype;
  } flt_entry_t;

  // Bit positions >= DATA_W never match the loop index, so such entries are inert.
  function automatic logic [DATA_W-1:0] fault_on_write(
    input flt_entry_t        e,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [DATA_W-1:0] cur_w
  );
    logic [DATA_W-1:0] res;
    res = cur_w;
    if ((e.ftype != FT_OFF) && (e.addr == addr)) begin
      for (int b = 0; b < DATA_W; b++) begin
        if (b == int'(e.bit_idx)) begin
          case (e.ftype)
            FT_SA0:  res[b] = 1'b0;
            FT_SA1:  res[b] = 1'b1;
            FT_TFU:  res[b] = (!old_w[b] && new_w[b]) ? old_w[b] : new_w[b];
            default: res[b] = new_w[b];
          endcase
        end
      end
    end
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] fault_on_read(
    input flt_entry_t        e,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] cur_w
  );
    logic [DATA_W-1:0] res;
    res = cur_w;
    if ((e.ftype != FT_OFF) && (e.addr == addr)) begin
      for (int b = 0; b < DATA_W; b++) begin
        if (b == int'(e.bit_idx)) begin
          case (e.ftype)
            FT_SA0:  res[b] = 1'b0;
            FT_SA1:  res[b] = 1'b1;
            default: res[b] = cur_w[b];
          endcase
        end
      end
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  flt_entry_t        flt_q [2];
  flt_entry_t        flt_d [2];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              wr_fire_s, rd_fire_s;
  logic [DATA_W-1:0] old_word_s, wr_word_s, rd_word_s;

  assign wr_fire_s  = ~bus.i_csn & ~bus.i_wen;
  assign rd_fire_s  = ~bus.i_csn &  bus.i_wen;
  assign old_word_s = mem_q[bus.i_addr];

  // Faulted write/read words; entry 0 is applied last so it wins on a shared bit.
  always_comb begin
    wr_word_s = fault_on_write(flt_q[0], bus.i_addr, old_word_s, bus.i_wr_data,
                  fault_on_write(flt_q[1], bus.i_addr, old_word_s, bus.i_wr_data,
                                 bus.i_wr_data));
    rd_word_s = fault_on_read(flt_q[0], bus.i_addr,
                  fault_on_read(flt_q[1], bus.i_addr, old_word_s));
  end

  // Fault table next state.
  always_comb begin
    flt_d = flt_q;
    if (bus.i_flt_wr) begin
      flt_d[bus.i_flt_idx] = '{addr:    bus.i_flt_addr,
                               bit_idx: bus.i_flt_bit,
                               ftype:   bus.i_flt_type};
    end else begin
      flt_d = flt_q;
    end
  end

  // Read port and saturating counters next state.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_fire_s;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    if (rd_fire_s) begin
      rd_data_d = rd_word_s;
    end else begin
      rd_data_d = rd_data_q;
    end
    if (bus.i_cnt_clr) begin
      wr_cnt_d = {CNT_W{1'b0}};
      rd_cnt_d = {CNT_W{1'b0}};
    end else begin
      if (wr_fire_s && (wr_cnt_q != {CNT_W{1'b1}})) begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end else begin
        wr_cnt_d = wr_cnt_q;
      end
      if (rd_fire_s && (rd_cnt_q != {CNT_W{1'b1}})) begin
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end else begin
        rd_cnt_d = rd_cnt_q;
      end
    end
  end

  // Memory array; cleared with the rest of the block on reset.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_fire_s) begin
      mem_q[bus.i_addr] <= wr_word_s;
    end
  end

  // Fault table, read-data and counter registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 2; i++) begin
        flt_q[i] <= '{addr: {ADDR_W{1'b0}}, bit_idx: 4'd0, ftype: FT_OFF};
      end
      rd_data_q  <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
      wr_cnt_q   <= {CNT_W{1'b0}};
      rd_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      flt_q      <= flt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_wr_cnt   = wr_cnt_q;
  assign bus.o_rd_cnt   = rd_cnt_q;

endmodule

// File: tb/tb_sram_fault_responder.sv
// Directed plus randomized bench for sram_fault_responder against a bit-level
// reference model of the memory and its fault table.
module tb_sram_fault_responder;
  localparam int DW   = 10;
  localparam int AW   = 8;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_fault_responder_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus_if ();

  sram_fault_responder #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_mem [256];
  logic [AW-1:0] m_faddr [2];
  int            m_fbit [2];
  logic [1:0]    m_ftype [2];
  int            m_wr, m_rd;
  logic [DW-1:0] m_rdata;
  logic          m_rvalid;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("rd_valid", 16'(bus_if.o_rd_valid), 16'(m_rvalid));
    chk("rd_data",  16'(bus_if.o_rd_data),  16'(m_rdata));
    chk("wr_cnt",   16'(bus_if.o_wr_cnt),   16'(m_wr));
    chk("rd_cnt",   16'(bus_if.o_rd_cnt),   16'(m_rd));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    for (int i = 0; i < 2; i++) begin
      m_faddr[i] = '0;
      m_fbit[i]  = 0;
      m_ftype[i] = 2'b00;
    end
    m_wr = 0; m_rd = 0; m_rdata = '0; m_rvalid = 1'b0;
  endtask

  // Which entry governs bit b of word a: 0, 1, or -1 for none.
  function automatic int governing(input logic [AW-1:0] a, input int b);
    for (int e = 0; e < 2; e++)
      if (m_ftype[e] != 2'b00 && m_faddr[e] == a && m_fbit[e] == b) return e;
    return -1;
  endfunction

  function automatic logic [DW-1:0] stored_val(input logic [AW-1:0] a, input logic [DW-1:0] nv);
    logic [DW-1:0] old, res;
    old = m_mem[a];
    for (int b = 0; b < DW; b++) begin
      int g;
      g = governing(a, b);
      res[b] = nv[b];
      if (g >= 0) begin
        if (m_ftype[g] == 2'b01) res[b] = 1'b0;
        else if (m_ftype[g] == 2'b10) res[b] = 1'b1;
        else if (old[b] == 1'b0) res[b] = 1'b0;   // TF-up: a 0 cell stays 0
      end
    end
    return res;
  endfunction

  function automatic logic [DW-1:0] readout(input logic [AW-1:0] a);
    logic [DW-1:0] res;
    res = m_mem[a];
    for (int b = 0; b < DW; b++) begin
      int g;
      g = governing(a, b);
      if (g >= 0) begin
        if (m_ftype[g] == 2'b01) res[b] = 1'b0;
        else if (m_ftype[g] == 2'b10) res[b] = 1'b1;
      end
    end
    return res;
  endfunction

  task automatic step(input logic csn, input logic wen, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic fwr, input logic fidx,
                      input logic [AW-1:0] fa, input logic [3:0] fb,
                      input logic [1:0] ft, input logic clr);
    bus_if.i_csn = csn;       bus_if.i_wen = wen;
    bus_if.i_addr = a;        bus_if.i_wr_data = wd;
    bus_if.i_flt_wr = fwr;    bus_if.i_flt_idx = fidx;
    bus_if.i_flt_addr = fa;   bus_if.i_flt_bit = fb;
    bus_if.i_flt_type = ft;   bus_if.i_cnt_clr = clr;
    @(posedge clk);
    if (!csn && !wen) begin
      m_mem[a] = stored_val(a, wd);
      m_rvalid = 1'b0;
      m_wr = (m_wr == MAXC) ? MAXC : m_wr + 1;
    end else if (!csn) begin
      m_rdata = readout(a);
      m_rvalid = 1'b1;
      m_rd = (m_rd == MAXC) ? MAXC : m_rd + 1;
    end else begin
      m_rvalid = 1'b0;
    end
    if (clr) begin m_wr = 0; m_rd = 0; end
    if (fwr) begin
      m_faddr[fidx] = fa; m_fbit[fidx] = int'(fb); m_ftype[fidx] = ft;
    end
    #1;
    check_outputs();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b0, 1'b0, a, d, 1'b0, 1'b0, 8'h00, 4'd0, 2'b00, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b1, a, 10'h000, 1'b0, 1'b0, 8'h00, 4'd0, 2'b00, 1'b0);
  endtask

  task automatic fld(input logic idx, input logic [AW-1:0] a, input logic [3:0] b, input logic [1:0] t);
    step(1'b1, 1'b1, 8'h00, 10'h000, 1'b1, idx, a, b, t, 1'b0);
  endtask

  initial begin
    model_reset();
    // Active access and fault load while in reset must be ignored.
    bus_if.i_csn = 1'b0;      bus_if.i_wen = 1'b0;
    bus_if.i_addr = 8'h33;    bus_if.i_wr_data = 10'h3FF;
    bus_if.i_flt_wr = 1'b1;   bus_if.i_flt_idx = 1'b0;
    bus_if.i_flt_addr = 8'h33; bus_if.i_flt_bit = 4'd0;
    bus_if.i_flt_type = 2'b10; bus_if.i_cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Fault-free write/read
    wr(8'h00, 10'h2AA);
    wr(8'hFF, 10'h155);
    rd(8'h00); chk("ff_rd0", 16'(bus_if.o_rd_data), 16'h02AA);
    rd(8'hFF); chk("ff_rdff", 16'(bus_if.o_rd_data), 16'h0155);
    chk("ff_wrcnt", 16'(bus_if.o_wr_cnt), 16'd2);
    chk("ff_rdcnt", 16'(bus_if.o_rd_cnt), 16'd2);
    rd(8'h33); chk("rst_ignored", 16'(bus_if.o_rd_data), 16'h0000);

    // Stuck-at
    fld(1'b0, 8'h10, 4'd3, 2'b10);
    fld(1'b1, 8'h10, 4'd9, 2'b01);
    wr(8'h10, 10'h200); rd(8'h10); chk("sa_a", 16'(bus_if.o_rd_data), 16'h0008);
    wr(8'h10, 10'h3FF); rd(8'h10); chk("sa_b", 16'(bus_if.o_rd_data), 16'h01FF);

    // TF-up
    fld(1'b0, 8'h20, 4'd0, 2'b11);
    wr(8'h20, 10'h000); wr(8'h20, 10'h001);
    rd(8'h20); chk("tf_blocked", 16'(bus_if.o_rd_data), 16'h0000);
    fld(1'b0, 8'h20, 4'd0, 2'b00);
    rd(8'h20); chk("tf_disabled", 16'(bus_if.o_rd_data), 16'h0000);
    wr(8'h20, 10'h001);
    rd(8'h20); chk("tf_after", 16'(bus_if.o_rd_data), 16'h0001);

    // Priority, same-edge load, out-of-range bit
    fld(1'b0, 8'h05, 4'd2, 2'b01);
    fld(1'b1, 8'h05, 4'd2, 2'b10);
    wr(8'h05, 10'h3FF); rd(8'h05); chk("prio", 16'(bus_if.o_rd_data), 16'h03FB);
    step(1'b0, 1'b0, 8'h31, 10'h001, 1'b1, 1'b0, 8'h31, 4'd0, 2'b11, 1'b0);
    rd(8'h31); chk("same_edge", 16'(bus_if.o_rd_data), 16'h0001);
    wr(8'h31, 10'h000); wr(8'h31, 10'h001);
    rd(8'h31); chk("next_edge", 16'(bus_if.o_rd_data), 16'h0000);
    fld(1'b1, 8'h06, 4'd12, 2'b10);
    wr(8'h06, 10'h000); rd(8'h06); chk("bit_oob", 16'(bus_if.o_rd_data), 16'h0000);

    // Counter saturation and clear priority
    repeat (20) rd(8'h00);
    chk("rd_sat", 16'(bus_if.o_rd_cnt), 16'd15);
    step(1'b0, 1'b1, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 4'd0, 2'b00, 1'b1);
    chk("clr_prio", 16'(bus_if.o_rd_cnt), 16'd0);

    // Randomized traffic with random fault programming
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 4) == 0), 1'($urandom), 8'($urandom_range(0, 7)),
           10'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom),
           8'($urandom_range(0, 7)), 4'($urandom_range(0, 11)), 2'($urandom),
           1'($urandom_range(0, 30) == 0));
    end

    // Reset in the middle of traffic, between edges
    fld(1'b0, 8'h10, 4'd3, 2'b10);
    wr(8'h10, 10'h000);
    wr(8'h00, 10'h3C3);
    rd(8'h10);
    chk("pre_rst", 16'(bus_if.o_rd_data), 16'h0008);
    bus_if.i_wen = 1'b0;
    #1 rst = 1'b1;
    #2;
    model_reset();
    check_outputs();
    chk("async_rd_data", 16'(bus_if.o_rd_data), 16'h0000);
    #1 rst = 1'b0;
    rd(8'h10); chk("post_rst_flt", 16'(bus_if.o_rd_data), 16'h0000);
    rd(8'h00); chk("post_rst_mem", 16'(bus_if.o_rd_data), 16'h0000);
    chk("post_rst_rdcnt", 16'(bus_if.o_rd_cnt), 16'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
